// File: rtl/mul_trunc_pipe.sv
// Pipelined unsigned multiplier with optional column truncation of the partial-product array.
// Define MUL_TRUNC_COMP_EN to add a saturating 2^(CUT-1) bias to truncated results.
module mul_trunc_pipe #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned CUT    = 15,
    parameter int unsigned STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] o
);

    localparam int unsigned OW = 2 * WIDTH;
`ifdef MUL_TRUNC_COMP_EN
    // One guard bit above the result so the final adder exposes overflow for saturation.
    localparam int unsigned PW = OW + 1;
    localparam logic [PW-1:0] COMP_ROW =
        (CUT == 0) ? '0 : (PW'(1) << ((CUT > 0) ? CUT - 1 : 0));
`else
    localparam int unsigned PW = OW;
`endif
    localparam int unsigned NREG = (STAGES > 1) ? STAGES - 1 : 1;
    localparam logic [PW-1:0] KEEP_MASK = ~((PW'(1) << CUT) - PW'(1));

    // 3:2 compressor across a whole row; returns {sum, carry}.
    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] s, input logic [PW-1:0] c,
                                            input logic [PW-1:0] r);
        logic [PW-1:0] maj;
        maj = (s & c) | (s & r) | (c & r);
        return {s ^ c ^ r, maj << 1};
    endfunction

    logic              en;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [PW-1:0]     front_sum, front_car, row, mask;
    logic [PW-1:0]     fin_sum, fin_car, fin_add;
    logic [OW-1:0]     o_d, o_q;
    logic [PW-1:0]     sum_q [NREG];
    logic [PW-1:0]     car_q [NREG];

    assign en        = !vld_q[STAGES-1] | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[STAGES-1];
    assign o         = o_q;

    // Carry-save reduction only; the single carry-propagate add sits in the last stage.
    always_comb begin
        front_sum = '0;
        front_car = '0;
        row       = '0;
        mask      = exact ? '1 : KEEP_MASK;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            row = a[i] ? ((PW'(b) << i) & mask) : '0;
            {front_sum, front_car} = csa(front_sum, front_car, row);
        end
`ifdef MUL_TRUNC_COMP_EN
        row = exact ? '0 : COMP_ROW;
        {front_sum, front_car} = csa(front_sum, front_car, row);
`endif
    end

    if (STAGES == 1) begin : g_direct
        assign fin_sum = front_sum;
        assign fin_car = front_car;
    end else begin : g_reg
        assign fin_sum = sum_q[NREG-1];
        assign fin_car = car_q[NREG-1];
    end

    always_comb begin
        fin_add = fin_sum + fin_car;
`ifdef MUL_TRUNC_COMP_EN
        o_d = fin_add[OW] ? '1 : fin_add[OW-1:0];
`else
        o_d = fin_add;
`endif
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sum_q[0] <= front_sum;
            car_q[0] <= front_car;
            for (int unsigned k = 1; k < NREG; k++) begin
                sum_q[k] <= sum_q[k-1];
                car_q[k] <= car_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            o_q   <= '0;
        end else begin
            if (clear) begin
                vld_q <= '0;
            end else if (en) begin
                vld_q <= vld_d;
            end
            if (en && vld_d[STAGES-1]) begin
                o_q <= o_d;
            end
        end
    end

endmodule

// File: tb/tb_mul_trunc_pipe.sv
// Directed and table-driven bench for mul_trunc_pipe at WIDTH=12, CUT=15, STAGES=2.
module tb_mul_trunc_pipe;

`ifdef MUL_TRUNC_COMP_EN
    localparam int COMP = 16384;
`else
    localparam int COMP = 0;
`endif

    logic        clk, rst_n, clear, in_valid, in_ready, exact, out_valid, out_ready;
    logic [11:0] a, b;
    logic [23:0] o;

    int total = 0;
    int bad   = 0;

    mul_trunc_pipe #(.WIDTH(12), .CUT(15), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .exact     (exact),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        ex;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Partial-product definition straight from the column rule, plus optional bias.
    function automatic logic [23:0] model(input logic [11:0] x, input logic [11:0] y,
                                          input logic ex);
        longint s;
        s = 0;
        if (ex) return 24'(longint'(x) * longint'(y));
        for (int i = 0; i < 12; i++)
            for (int j = 0; j < 12; j++)
                if (i + j >= 15 && x[i] && y[j]) s += longint'(1) << (i + j);
        s += COMP;
        if (s > 64'hFFFFFF) s = 64'hFFFFFF;
        return 24'(s);
    endfunction

    task automatic drive(input logic [11:0] x, input logic [11:0] y, input logic ex);
        a = x; b = y; exact = ex; in_valid = 1;
    endtask

    logic [23:0] exp_q [$];
    logic [23:0] held, want;
    logic        stalled;
    int          sent, got, cyc;

    initial begin
        vecs[0] = '{12'd4095, 12'd4095, 1'b0, 24'(16449536 + COMP)};
        vecs[1] = '{12'd4095, 12'd4095, 1'b1, 24'hFFE001};
        vecs[2] = '{12'd128,  12'd128,  1'b0, 24'(COMP)};
        vecs[3] = '{12'd128,  12'd128,  1'b1, 24'd16384};
        vecs[4] = '{12'd2048, 12'd2048, 1'b0, 24'(4194304 + COMP)};
        vecs[5] = '{12'd1,    12'd1,    1'b0, 24'(COMP)};
        vecs[6] = '{12'd1,    12'd1,    1'b1, 24'd1};
        vecs[7] = '{12'd0,    12'd4095, 1'b1, 24'd0};
        vecs[8] = '{12'd3000, 12'd1000, 1'b1, 24'd3000000};

        rst_n = 0; clear = 0; in_valid = 0; a = 0; b = 0; exact = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_o", 32'(o), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1;

        // Single transactions: latency exactly two cycles
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            drive(vecs[v].a, vecs[v].b, vecs[v].ex);
            @(negedge clk);
            in_valid = 0;
            check($sformatf("vec%0d_early", v), 32'(out_valid), 0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", v), 32'(out_valid), 1);
            check($sformatf("vec%0d_o", v), 32'(o), 32'(vecs[v].exp));
        end

        // Mixed-mode back-to-back
        @(negedge clk);
        drive(12'd4095, 12'd4095, 1'b0);
        @(negedge clk);
        drive(12'd4095, 12'd4095, 1'b1);
        @(negedge clk);
        in_valid = 0;
        check("mix_first", 32'(o), 32'(vecs[0].exp));
        @(negedge clk);
        check("mix_second_valid", 32'(out_valid), 1);
        check("mix_second", 32'(o), 32'hFFE001);

        // Ten transfers against random back-pressure
        @(negedge clk);
        sent = 0; got = 0; cyc = 0; stalled = 0; held = '0;
        drive(12'($urandom), 12'($urandom), 1'($urandom));
        while (got < 10 && cyc < 300) begin
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_o", 32'(o), 32'(held));
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            stalled = out_valid && !out_ready;
            held    = o;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra", 32'(o), 32'hFFFFFFFF);
                end else begin
                    want = exp_q.pop_front();
                    check($sformatf("stream%0d", got), 32'(o), 32'(want));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, exact));
                sent++;
            end
            @(negedge clk);
            cyc++;
            if (!in_ready && in_valid) begin
                // held operands stay put until accepted
            end else if (sent < 10) begin
                drive(12'($urandom), 12'($urandom), 1'($urandom));
            end else begin
                in_valid = 0;
            end
        end
        if (got < 10) check("stream_timeout", 32'(got), 10);
        in_valid = 0;
        out_ready = 1;
        repeat (3) @(negedge clk);

        // Reset with two transactions in flight
        out_ready = 0;
        drive(12'd4095, 12'd4095, 1'b1);
        @(negedge clk);
        drive(12'd2048, 12'd2048, 1'b0);
        @(negedge clk);
        in_valid = 0;
        rst_n = 0;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_o", 32'(o), 0);
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        drive(12'd2048, 12'd2048, 1'b0);
        @(negedge clk);
        in_valid = 0;
        check("postrst_early", 32'(out_valid), 0);
        @(negedge clk);
        check("postrst_valid", 32'(out_valid), 1);
        check("postrst_o", 32'(o), 32'(vecs[4].exp));
        @(negedge clk);

        // Clear with the pipeline full and stalled
        out_ready = 0;
        drive(12'd100, 12'd200, 1'b1);
        @(negedge clk);
        drive(12'd300, 12'd400, 1'b1);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 0);
        drive(12'd500, 12'd600, 1'b1);
        clear = 1;
        @(negedge clk);
        clear = 0;
        in_valid = 0;
        check("clear_valid", 32'(out_valid), 0);
        check("clear_in_ready", 32'(in_ready), 1);
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("clear_drain%0d", k), 32'(out_valid), 0);
        end

        // Clear while flowing discards same-cycle operands
        drive(12'd7, 12'd9, 1'b1);
        clear = 1;
        @(negedge clk);
        clear = 0;
        in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("clear_flow%0d", k), 32'(out_valid), 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_trunc_pipe.md
MUL_TRUNC_PIPE -- requirements
Module: mul_trunc_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, operand width in bits (legal 4..32).
REQ-002 The block SHALL have parameter CUT, default 15, lowest kept partial-product column (legal 0..2*WIDTH-2).
REQ-003 The block SHALL have parameter STAGES, default 2, register stages from input to output (legal 1..4).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all flops on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous flush of all pipeline valids.
REQ-007 The block SHALL have port in_valid, input, 1 bit: operand transfer request.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-009 The block SHALL have port a, input, WIDTH bits: unsigned operand A.
REQ-010 The block SHALL have port b, input, WIDTH bits: unsigned operand B.
REQ-011 The block SHALL have port exact, input, 1 bit: per-transaction mode; 1 = exact product, 0 = truncated.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-014 The block SHALL have port o, output, 2*WIDTH bits: unsigned result.

Function
REQ-015 In truncated mode, o SHALL equal the sum over all i,j with i+j >= CUT of (a[i]&b[j])<<(i+j); no partial product with i+j < CUT contributes, and o[CUT-1:0] is 0.
REQ-016 In exact mode, o SHALL equal a*b, full 2*WIDTH bits.
REQ-017 exact SHALL be captured with its operands and travel with the transaction; mixed-mode back-to-back transactions SHALL each use their own mode.
REQ-018 Pipeline enable SHALL be en = !out_valid | out_ready; in_ready SHALL equal en; all stages advance together when en = 1 and hold when en = 0.
REQ-019 A transfer occurs when in_valid & in_ready; the result SHALL appear at o with out_valid = 1 exactly STAGES cycles later when en stays 1.
REQ-020 Throughput SHALL be one transaction per cycle with out_ready held 1; no transaction is dropped or duplicated under any out_ready pattern.
REQ-021 While out_valid = 1 and out_ready = 0, o and out_valid SHALL remain stable.
REQ-022 Partial-product accumulation SHALL be split across stages so that no single stage performs more than one full-width carry-propagate addition.
REQ-023 clear = 1 SHALL zero every stage valid on the next edge, regardless of en; operands presented the same cycle SHALL be discarded; in_ready is unaffected by clear.

Reset
REQ-024 While rst_n = 0, all stage valids and out_valid SHALL be 0 and o SHALL be 0; in_ready then reads 1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight transactions; the first transfer after release SHALL produce a correct result after STAGES cycles.
REQ-026 Operand/data pipeline registers other than o need not be reset.

Configuration
REQ-027 With macro MUL_TRUNC_COMP_EN defined, truncated-mode results SHALL add the constant 2^(CUT-1) (0 when CUT = 0), saturating at 2^(2*WIDTH)-1; exact mode SHALL be unaffected.
REQ-028 Without MUL_TRUNC_COMP_EN, no compensation logic SHALL exist and REQ-015 applies unmodified.

Verification (WIDTH=12, CUT=15, STAGES=2)
REQ-029 The bench SHALL cover: a=4095, b=4095, exact=0 -> o=0xFB0000 (16449536) at cycle +2; exact=1 -> o=0xFFE001.
REQ-030 The bench SHALL cover: a=128, b=128, exact=0 -> o=0; exact=1 -> o=16384; a=2048, b=2048, exact=0 -> o=4194304.
REQ-031 The bench SHALL cover: a=1, b=1, exact=0 with MUL_TRUNC_COMP_EN defined -> o=16384; without it -> o=0.
REQ-032 The bench SHALL cover: 10 back-to-back transfers with random out_ready -> 10 results in order, each matching a reference model, with o stable while stalled.
REQ-033 The bench SHALL cover: rst_n pulsed low with 2 transactions in flight -> out_valid=0 and o=0 immediately; the next transfer yields a correct result at +2.
REQ-034 The bench SHALL cover: clear=1 with the pipeline full and out_ready=0 -> out_valid=0 next cycle, and in_ready=1.
